ysyx_22041211_pc_gen: RTL
=========================

# ysyx_22041211_pc_gen

Parametrised program-counter generator for the NPC fetch front end: holds the architectural PC, presents it to the IFU via a valid/ready handshake, and advances it on acceptance. It also applies prioritised trap and branch redirects with misalignment checking, supports halt, and exports PC/next-PC and a fetch counter for difftest hooks. It sits between the EXU/CSR redirect sources and the IFU.

## Interface
- ADDR_LEN, 32: PC/target width in bits.
- RESET_VAL, 32'h8000_0000: PC loaded on reset.
- INST_BYTES, 4: sequential step in bytes (2 or 4); also the alignment unit for targets.
- CNT_W, 64: fetch counter width.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- pc_valid_o  out  1  pc_o is a fetch request.
- pc_ready_i  in  1  IFU accepts pc_o; fire = pc_valid_o & pc_ready_i.
- pc_o  out  ADDR_LEN  current PC.
- dnpc_o  out  ADDR_LEN  combinational next-PC (value pc_o takes at next edge).
- branch_flag_i  in  1  branch/jump taken from EXU.
- branch_target_i  in  ADDR_LEN  branch target.
- trap_flag_i  in  1  trap/mret redirect from CSR unit.
- trap_target_i  in  ADDR_LEN  trap/mret target.
- halt_i  in  1  ebreak: stop fetching.
- flush_o  out  1  one-cycle pulse: redirect applied this edge, IFU drops in-flight fetch.
- misalign_o  out  1  one-cycle pulse: selected target not INST_BYTES-aligned.
- fetch_cnt_o  out  CNT_W  count of fires since reset.

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset (rst=0, async): state=BOOT, pc_o=RESET_VAL, pc_valid_o=0, flush_o=0, misalign_o=0, fetch_cnt_o=0.
- BOOT: pc_valid_o=0; unconditionally -> RUN on the next edge; redirects in BOOT ignored.
- RUN: pc_valid_o=1.
- Redirect select priority: halt_i > trap_flag_i > branch_flag_i > sequential.
- halt_i in RUN -> HALT; pc_o frozen; pc_valid_o=0 from next cycle. HALT exits only via reset.
- Redirect with aligned target: pc_o <= target, flush_o=1 next cycle, regardless of pc_ready_i.
- Redirect with misaligned target (target mod INST_BYTES != 0): pc_o unchanged, misalign_o=1 next cycle, flush_o=0; a lower-priority redirect in the same cycle is NOT substituted.
- No redirect: fire -> pc_o <= pc_o + INST_BYTES; no fire -> pc_o holds.
- dnpc_o always equals the pc_o value after the coming edge, per the rules above.
- Arithmetic: pc_o + INST_BYTES truncated to ADDR_LEN (wraps 0xFFFF_FFFC -> 0x0 for 32/4). fetch_cnt_o wraps at 2^CNT_W.
- fetch_cnt_o increments on every fire, including the one coinciding with a redirect.

## Timing
- Reset-to-first-request: pc_valid_o rises on the 1st edge after rst deasserts (BOOT lasts exactly one cycle).
- Sequential throughput: one PC per cycle while pc_ready_i=1.
- Redirect latency: one edge; the target appears on pc_o with pc_valid_o=1 in the cycle after the flag.
- Stall: pc_ready_i=0 holds pc_o/pc_valid_o stable; valid never drops without a redirect, halt or reset.
- Redirect and fire in the same cycle: redirect wins for pc_o; fire is counted.
- Reset mid-operation: immediate return to reset values; no pulse outputs survive.

## Structure
- Shared package ysyx_22041211_pkg: pc_gen state enum (BOOT/RUN/HALT), default RESET_VAL constant, redirect-source encoding.
- Sub-module ysyx_22041211_redirect_arb: combinational priority select plus alignment check, returning {valid, target, misaligned}. The FSM, PC register and counter stay in pc_gen.

## Test plan
- Reset then ready=1 for 4 cycles -> pc_o 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C; fetch_cnt_o=4; valid low only in BOOT.
- Ready held 0 for 3 cycles at 0x8000_0008 -> pc_o and valid stable, fetch_cnt_o unchanged.
- branch_flag_i=1 with target 0x8000_0100 and trap_flag_i=1 with target 0x8000_0200, together -> pc_o=0x8000_0200, flush_o pulse for one cycle.
- branch_target_i=0x8000_0102 (INST_BYTES=4) -> misalign_o pulse, pc_o unchanged, no flush.
- PC at 0xFFFF_FFFC with fire -> pc_o=0x0000_0000. halt_i -> valid low, PC frozen until reset.
- Assert rst for 1 cycle during a stall -> pc_o=RESET_VAL, fetch_cnt_o=0, BOOT reentered.

Source files
------------

// File: rtl/ysyx_22041211_pkg.sv
// Shared types and constants for the NPC fetch front end.
package ysyx_22041211_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_TRAP   = 2'd2
  } redir_src_e;

  localparam logic [31:0] DEFAULT_RESET_VAL = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22041211_redirect_arb.sv
// Priority select between trap and branch redirects, plus target alignment check.
module ysyx_22041211_redirect_arb
  import ysyx_22041211_pkg::*;
#(
  parameter int ADDR_LEN   = 32,
  parameter int INST_BYTES = 4
) (
  input  logic                branch_flag_i,
  input  logic [ADDR_LEN-1:0] branch_target_i,
  input  logic                trap_flag_i,
  input  logic [ADDR_LEN-1:0] trap_target_i,
  output logic                redir_valid_o,
  output logic [ADDR_LEN-1:0] redir_target_o,
  output logic                redir_misalign_o
);

  localparam int ALIGN_W = $clog2(INST_BYTES);

  redir_src_e w_src;

  always_comb begin
    w_src = SRC_SEQ;
    if (trap_flag_i)        w_src = SRC_TRAP;
    else if (branch_flag_i) w_src = SRC_BRANCH;
  end

  // Only the winning target is checked; a misaligned winner is never
  // replaced by a lower-priority candidate.
  always_comb begin
    redir_target_o = '0;
    case (w_src)
      SRC_TRAP:   redir_target_o = trap_target_i;
      SRC_BRANCH: redir_target_o = branch_target_i;
      default:    redir_target_o = '0;
    endcase
    redir_valid_o    = (w_src != SRC_SEQ);
    redir_misalign_o = redir_valid_o && (redir_target_o[ALIGN_W-1:0] != '0);
  end

endmodule

// File: rtl/ysyx_22041211_pc_gen.sv
// Program-counter generator: holds the PC, offers it to the IFU and applies redirects.
module ysyx_22041211_pc_gen
  import ysyx_22041211_pkg::*;
#(
  parameter int                  ADDR_LEN   = 32,
  parameter logic [ADDR_LEN-1:0] RESET_VAL  = DEFAULT_RESET_VAL,
  parameter int                  INST_BYTES = 4,
  parameter int                  CNT_W      = 64
) (
  input  logic                clk,
  input  logic                rst,
  output logic                pc_valid_o,
  input  logic                pc_ready_i,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [ADDR_LEN-1:0] dnpc_o,
  input  logic                branch_flag_i,
  input  logic [ADDR_LEN-1:0] branch_target_i,
  input  logic                trap_flag_i,
  input  logic [ADDR_LEN-1:0] trap_target_i,
  input  logic                halt_i,
  output logic                flush_o,
  output logic                misalign_o,
  output logic [CNT_W-1:0]    fetch_cnt_o,
  output logic [1:0]          state_o
);

  pc_state_e           r_state, w_state_nxt;
  logic [ADDR_LEN-1:0] r_pc, w_pc_nxt;
  logic                r_flush, w_flush_nxt;
  logic                r_misalign, w_misalign_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_fire;
  logic                w_redir_valid;
  logic [ADDR_LEN-1:0] w_redir_target;
  logic                w_redir_misalign;

  ysyx_22041211_redirect_arb #(
    .ADDR_LEN  (ADDR_LEN),
    .INST_BYTES(INST_BYTES)
  ) u_arb (
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .trap_flag_i     (trap_flag_i),
    .trap_target_i   (trap_target_i),
    .redir_valid_o   (w_redir_valid),
    .redir_target_o  (w_redir_target),
    .redir_misalign_o(w_redir_misalign)
  );

  // Handshake: pc_o is a request whenever pc_valid_o is high; a transfer
  // (fire) happens on an edge where pc_valid_o & pc_ready_i. Valid is a pure
  // function of state, so it never drops while the IFU stalls.
  assign pc_valid_o = (r_state == ST_RUN);
  assign w_fire     = pc_valid_o & pc_ready_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_flush_nxt    = 1'b0;
    w_misalign_nxt = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (halt_i) begin
          w_state_nxt = ST_HALT;
        end else if (w_redir_valid) begin
          if (w_redir_misalign) begin
            w_misalign_nxt = 1'b1;
          end else begin
            w_pc_nxt    = w_redir_target;
            w_flush_nxt = 1'b1;
          end
        end else if (w_fire) begin
          w_pc_nxt = r_pc + ADDR_LEN'(INST_BYTES);
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VAL;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_flush    <= w_flush_nxt;
      r_misalign <= w_misalign_nxt;
      if (w_fire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign pc_o        = r_pc;
  assign dnpc_o      = w_pc_nxt;
  assign flush_o     = r_flush;
  assign misalign_o  = r_misalign;
  assign fetch_cnt_o = r_cnt;
  assign state_o     = r_state;

endmodule
